// File: rtl/dca_matrix_store_arbiter_if.sv
// Bundle of request, unit-control and row-stream signals between the store
// arbiter (master) and the mreg-to-store units plus store engine (slave).
interface dca_matrix_store_arbiter_if #(
  parameter int NUM_REQUESTER = 2,
  parameter int BW_TENSOR_ROW = 128
);
  logic [NUM_REQUESTER-1:0]               sreq_wrequest;
  logic [NUM_REQUESTER-1:0]               sreq_wready;
  logic [NUM_REQUESTER-1:0]               unit_wrequest;
  logic [NUM_REQUESTER-1:0]               unit_wready;
  logic [NUM_REQUESTER-1:0]               unit_busy;
  logic [NUM_REQUESTER-1:0]               unit_rvalid;
  logic [NUM_REQUESTER-1:0]               unit_rlast;
  logic [NUM_REQUESTER-1:0]               unit_rready;
  logic [NUM_REQUESTER*BW_TENSOR_ROW-1:0] unit_rdata_list1d;
  logic                                   store_wrequest;
  logic                                   store_wready;
  logic                                   store_rvalid;
  logic                                   store_rlast;
  logic                                   store_rready;
  logic [BW_TENSOR_ROW-1:0]               store_rdata;

  modport master (
    input  sreq_wrequest, unit_wready, unit_busy, unit_rready, unit_rdata_list1d,
    input  store_wready, store_rvalid, store_rlast,
    output sreq_wready, unit_wrequest, unit_rvalid, unit_rlast,
    output store_wrequest, store_rready, store_rdata
  );

  modport slave (
    output sreq_wrequest, unit_wready, unit_busy, unit_rready, unit_rdata_list1d,
    output store_wready, store_rvalid, store_rlast,
    input  sreq_wready, unit_wrequest, unit_rvalid, unit_rlast,
    input  store_wrequest, store_rready, store_rdata
  );
endinterface

// File: rtl/dca_matrix_store_arbiter.sv
// Shares one store engine among NUM_REQUESTER mreg-to-store units: grant, issue, stream, drain.
// Define DCA_STORE_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module dca_matrix_store_arbiter #(
  parameter int NUM_REQUESTER = 2,
  parameter int BW_TENSOR_ROW = 128
) (
  input  logic                             clk,
  input  logic                             rstnn,
  input  logic                             clear,
  input  logic                             enable,
  output logic                             busy,
  output logic [$clog2(NUM_REQUESTER)-1:0] grant_index,
  dca_matrix_store_arbiter_if.master       bus
);
  localparam int GW = $clog2(NUM_REQUESTER);

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DRAIN} state_t;

  state_t                   state_reg;
  logic [GW-1:0]            grant_reg;
  logic [NUM_REQUESTER-1:0] unit_wrequest_reg;
  logic                     store_wrequest_reg;
  logic                     busy_reg;

  logic [NUM_REQUESTER-1:0] eligible;
  logic [GW-1:0]            winner;
  logic                     start;
  logic                     streaming;

  assign eligible  = bus.sreq_wrequest & bus.unit_wready;
  // A grant is only taken on an edge that will actually move the FSM.
  assign start     = (state_reg == IDLE) && enable && !clear && !rstnn
                     && (|eligible) && bus.store_wready;
  assign streaming = (state_reg == STREAM);

`ifdef DCA_STORE_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] ptr_reg;

  always_comb begin
    int idx;
    winner = '0;
    idx    = 0;
    // Scan backwards so the closest eligible index at/after the pointer wins last.
    for (int k = NUM_REQUESTER - 1; k >= 0; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQUESTER) idx = idx - NUM_REQUESTER;
      if (eligible[idx]) winner = GW'(idx);
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int k = NUM_REQUESTER - 1; k >= 0; k--) begin
      if (eligible[k]) winner = GW'(k);
    end
  end
`endif

  for (genvar gi = 0; gi < NUM_REQUESTER; gi++) begin : g_route
    logic sel;
    assign sel                 = streaming && (grant_reg == GW'(gi));
    assign bus.unit_rvalid[gi] = sel & bus.store_rvalid;
    assign bus.unit_rlast[gi]  = sel & bus.store_rlast;
    assign bus.sreq_wready[gi] = start && (winner == GW'(gi));
  end

  assign bus.store_rready   = streaming & bus.unit_rready[grant_reg];
  assign bus.store_rdata    = streaming
                              ? bus.unit_rdata_list1d[int'(grant_reg)*BW_TENSOR_ROW +: BW_TENSOR_ROW]
                              : '0;
  assign bus.unit_wrequest  = unit_wrequest_reg;
  assign bus.store_wrequest = store_wrequest_reg;
  assign busy               = busy_reg;
  assign grant_index        = grant_reg;

  always_ff @(posedge clk) begin
    if (rstnn || clear) begin
      state_reg          <= IDLE;
      grant_reg          <= '0;
      unit_wrequest_reg  <= '0;
      store_wrequest_reg <= 1'b0;
      busy_reg           <= 1'b0;
`ifdef DCA_STORE_ARB_ROUND_ROBIN_EN
      ptr_reg            <= '0;
`endif
    end else if (enable) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            grant_reg          <= winner;
            unit_wrequest_reg  <= {{(NUM_REQUESTER-1){1'b0}}, 1'b1} << winner;
            store_wrequest_reg <= 1'b1;
            busy_reg           <= 1'b1;
            state_reg          <= ISSUE;
          end
        end
        ISSUE: begin
          unit_wrequest_reg  <= '0;
          store_wrequest_reg <= 1'b0;
          state_reg          <= STREAM;
        end
        STREAM: begin
          if (bus.store_rvalid && bus.store_rready && bus.store_rlast) state_reg <= DRAIN;
        end
        DRAIN: begin
          // Unit must finish its own bookkeeping before the port is reusable.
          if (!bus.unit_busy[grant_reg]) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
`ifdef DCA_STORE_ARB_ROUND_ROBIN_EN
            ptr_reg   <= (int'(grant_reg) == NUM_REQUESTER - 1) ? '0 : grant_reg + 1'b1;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dca_matrix_store_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, random run against a job-level model.
module tb_dca_matrix_store_arbiter;
  localparam int N  = 3;
  localparam int BW = 16;

  logic       clk = 1'b0;
  logic       rstnn, clear, enable, busy;
  logic [1:0] grant_index;
  int         errors = 0;
  int         checks = 0;

  dca_matrix_store_arbiter_if #(.NUM_REQUESTER(N), .BW_TENSOR_ROW(BW)) bus ();

  dca_matrix_store_arbiter #(.NUM_REQUESTER(N), .BW_TENSOR_ROW(BW)) dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
    .busy(busy), .grant_index(grant_index), .bus(bus)
  );

  always #5 clk = ~clk;

  // Job-level reference: is a job open, who owns it, has the start pulse gone out, has the last row passed.
  bit m_busy, m_issued, m_done;
  int m_owner, m_ptr, jobs;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] uwr;
    logic         sw;
    logic         en;
    logic [N-1:0] exp_ack;
    logic         exp_busy;
    logic [1:0]   exp_grant;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    clear = 0; enable = 0;
    bus.sreq_wrequest = '0; bus.unit_wready = '0; bus.unit_busy = '0;
    bus.unit_rready = '0; bus.unit_rdata_list1d = '0;
    bus.store_wready = 0; bus.store_rvalid = 0; bus.store_rlast = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rstnn = 1;
    tick();
    rstnn = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_index, 0);
    chk("rst_sreq_wready", bus.sreq_wready, 0);
    chk("rst_unit_wreq", bus.unit_wrequest, 0);
    chk("rst_store_wreq", bus.store_wrequest, 0);
    chk("rst_rvalid", bus.unit_rvalid, 0);
    chk("rst_rready", bus.store_rready, 0);
    chk("rst_rdata", bus.store_rdata, 0);
    m_busy = 0; m_issued = 0; m_done = 0; m_ptr = 0; m_owner = 0;
  endtask

  function automatic int pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
`ifdef DCA_STORE_ARB_ROUND_ROBIN_EN
      int idx = (ptr + k) % N;
`else
      int idx = k + 0 * ptr;
`endif
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_check();
    logic [N-1:0] exp_ack, exp_uw, exp_rv, exp_rl;
    logic [BW-1:0] exp_rd;
    bit stream;
    int g;
    g = pick(bus.sreq_wrequest & bus.unit_wready, m_ptr);
    exp_ack = '0; exp_uw = '0; exp_rv = '0; exp_rl = '0; exp_rd = '0;
    if (!m_busy && enable && !clear && !rstnn && bus.store_wready && g >= 0) exp_ack[g] = 1'b1;
    if (m_busy && !m_issued) exp_uw[m_owner] = 1'b1;
    stream = m_busy && m_issued && !m_done;
    if (stream) begin
      exp_rv[m_owner] = bus.store_rvalid;
      exp_rl[m_owner] = bus.store_rlast;
      exp_rd = bus.unit_rdata_list1d[m_owner*BW +: BW];
    end
    chk("rnd_sreq_wready", bus.sreq_wready, exp_ack);
    chk("rnd_unit_wreq", bus.unit_wrequest, exp_uw);
    chk("rnd_store_wreq", bus.store_wrequest, (m_busy && !m_issued) ? 1 : 0);
    chk("rnd_rvalid", bus.unit_rvalid, exp_rv);
    chk("rnd_rlast", bus.unit_rlast, exp_rl);
    chk("rnd_rready", bus.store_rready, (stream && bus.unit_rready[m_owner]) ? 1 : 0);
    chk("rnd_rdata", bus.store_rdata, exp_rd);
    chk("rnd_busy", busy, m_busy);
    if (m_busy) chk("rnd_grant", grant_index, m_owner);
  endtask

  task automatic model_update();
    int g;
    g = pick(bus.sreq_wrequest & bus.unit_wready, m_ptr);
    if (rstnn || clear) begin
      m_busy = 0; m_issued = 0; m_done = 0; m_ptr = 0;
    end else if (enable) begin
      if (!m_busy) begin
        if (bus.store_wready && g >= 0) begin
          m_busy = 1; m_owner = g; m_issued = 0; m_done = 0; jobs++;
          $display("job %0d: granted requester %0d", jobs, g);
        end
      end else if (!m_issued) begin
        m_issued = 1;
      end else if (!m_done) begin
        if (bus.store_rvalid && bus.unit_rready[m_owner] && bus.store_rlast) m_done = 1;
      end else if (!bus.unit_busy[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  function automatic logic [N-1:0] rand_bits(input int pct);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < pct);
    return v;
  endfunction

  task automatic start_job(input int g);
    bus.sreq_wrequest = 3'b001 << g;
    bus.unit_wready = '1; bus.store_wready = 1; bus.unit_rready = '1; enable = 1;
    tick();
    bus.sreq_wrequest = '0;
    tick();
  endtask

  task automatic do_job(input int g);
    bus.unit_wready = '1; bus.store_wready = 1; bus.unit_rready = '1;
    bus.unit_busy = '0; enable = 1;
    #1;
    chk("job_ack", bus.sreq_wready, 3'b001 << g);
    tick();
    tick();
    bus.store_rvalid = 1; bus.store_rlast = 1;
    #1;
    chk("job_grant", grant_index, g);
    chk("job_rvalid", bus.unit_rvalid, 3'b001 << g);
    tick();
    bus.store_rvalid = 0; bus.store_rlast = 0;
    tick();
  endtask

  initial begin
    rstnn = 1;
    zero_inputs();
    jobs = 0;

    // req, unit_wready, store_wready, enable -> ack, busy after edge, grant
    vecs[0] = '{3'b001, 3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 2'd0};
    vecs[1] = '{3'b110, 3'b111, 1'b1, 1'b1, 3'b010, 1'b1, 2'd1};
    vecs[2] = '{3'b110, 3'b101, 1'b1, 1'b1, 3'b100, 1'b1, 2'd2};
    vecs[3] = '{3'b011, 3'b001, 1'b1, 1'b1, 3'b001, 1'b1, 2'd0};
    vecs[4] = '{3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 1'b0, 2'd0};
    vecs[5] = '{3'b111, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0};
    vecs[6] = '{3'b100, 3'b011, 1'b1, 1'b1, 3'b000, 1'b0, 2'd0};
    vecs[7] = '{3'b000, 3'b111, 1'b1, 1'b1, 3'b000, 1'b0, 2'd0};
    vecs[8] = '{3'b101, 3'b100, 1'b1, 1'b1, 3'b100, 1'b1, 2'd2};

    for (int v = 0; v < 9; v++) begin
      do_reset();
      bus.sreq_wrequest = vecs[v].req; bus.unit_wready = vecs[v].uwr;
      bus.store_wready = vecs[v].sw; enable = vecs[v].en;
      #1;
      chk("vec_ack", bus.sreq_wready, vecs[v].exp_ack);
      tick();
      chk("vec_busy", busy, vecs[v].exp_busy);
      chk("vec_unit_wreq", bus.unit_wrequest, vecs[v].exp_ack);
      if (vecs[v].exp_busy) chk("vec_grant", grant_index, vecs[v].exp_grant);
    end

    // Four-row burst to unit 0, then drain gated by unit_busy[0].
    do_reset();
    bus.unit_wready = '1; bus.store_wready = 1; bus.unit_rready = '1;
    bus.unit_busy = 3'b001; enable = 1; bus.sreq_wrequest = 3'b001;
    #1;
    chk("burst_ack", bus.sreq_wready, 3'b001);
    tick();
    bus.sreq_wrequest = '0;
    #1;
    chk("burst_unit_wreq", bus.unit_wrequest, 3'b001);
    chk("burst_store_wreq", bus.store_wrequest, 1);
    chk("burst_busy", busy, 1);
    tick();
    for (int r = 0; r < 4; r++) begin
      bus.store_rvalid = 1; bus.store_rlast = (r == 3);
      bus.unit_rdata_list1d = {16'h3333, 16'h5555, 16'(16'hA000 + r)};
      #1;
      if (r == 0) begin
        chk("burst_pulse_end", bus.unit_wrequest, 0);
        chk("burst_store_pulse_end", bus.store_wrequest, 0);
      end
      chk("burst_rvalid", bus.unit_rvalid, 3'b001);
      chk("burst_rlast", bus.unit_rlast, (r == 3) ? 1 : 0);
      chk("burst_rdata", bus.store_rdata, 16'hA000 + r);
      chk("burst_rready", bus.store_rready, 1);
      tick();
    end
    bus.store_rvalid = 0; bus.store_rlast = 0; bus.sreq_wrequest = 3'b011;
    for (int d = 0; d < 2; d++) begin
      #1;
      chk("drain_busy", busy, 1);
      chk("drain_ack", bus.sreq_wready, 0);
      chk("drain_rdata", bus.store_rdata, 0);
      tick();
    end
    bus.unit_busy = '0;
    #1;
    chk("drain_exit_ack", bus.sreq_wready, 0);
    tick();
    chk("drain_done_busy", busy, 0);
    bus.sreq_wrequest = '0;

    // Two jobs with both requesters held, then requester 0 withdraws.
    do_reset();
    bus.sreq_wrequest = 3'b011;
    do_job(0);
`ifdef DCA_STORE_ARB_ROUND_ROBIN_EN
    do_job(1);
`else
    do_job(0);
`endif
    bus.sreq_wrequest = 3'b010;
    do_job(1);
    bus.sreq_wrequest = '0;

    // Clear after two streamed rows drops the transfer.
    do_reset();
    start_job(1);
    bus.store_rvalid = 1; bus.store_rlast = 0;
    tick();
    tick();
    clear = 1;
    tick();
    clear = 0;
    #1;
    chk("clear_rready", bus.store_rready, 0);
    chk("clear_rvalid", bus.unit_rvalid, 0);
    chk("clear_busy", busy, 0);
    chk("clear_grant", grant_index, 0);
    bus.store_rvalid = 0;

    // enable=0 freezes DRAIN even with the unit already idle.
    do_reset();
    start_job(2);
    bus.store_rvalid = 1; bus.store_rlast = 1;
    tick();
    bus.store_rvalid = 0; bus.store_rlast = 0; bus.unit_busy = '0; enable = 0;
    for (int d = 0; d < 3; d++) begin
      tick();
      chk("freeze_busy", busy, 1);
      chk("freeze_grant", grant_index, 2);
    end
    enable = 1;
    tick();
    chk("unfreeze_busy", busy, 0);

    // Store engine not ready holds IDLE until it rises.
    do_reset();
    bus.sreq_wrequest = 3'b011; bus.unit_wready = '1; enable = 1; bus.store_wready = 0;
    for (int d = 0; d < 3; d++) begin
      #1;
      chk("swr_low_ack", bus.sreq_wready, 0);
      tick();
      chk("swr_low_busy", busy, 0);
    end
    bus.store_wready = 1;
    #1;
    chk("swr_rise_ack", bus.sreq_wready, 3'b001);
    tick();
    chk("swr_rise_busy", busy, 1);
    chk("swr_rise_grant", grant_index, 0);

    // Randomised run against the job-level model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rstnn  = ($urandom_range(0, 199) == 0);
      clear  = ($urandom_range(0, 79) == 0);
      enable = ($urandom_range(0, 99) < 85);
      bus.sreq_wrequest     = rand_bits(40);
      bus.unit_wready       = rand_bits(75);
      bus.unit_busy         = rand_bits(50);
      bus.unit_rready       = rand_bits(70);
      bus.store_wready      = ($urandom_range(0, 99) < 70);
      bus.store_rvalid      = ($urandom_range(0, 99) < 60);
      bus.store_rlast       = ($urandom_range(0, 99) < 25);
      bus.unit_rdata_list1d = {16'($urandom), 16'($urandom), 16'($urandom)};
      #1;
      model_check();
      model_update();
      tick();
    end
    rstnn = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
